// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline run/stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } pctrl_state_t;

    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned DRAIN_W      = 2;

    // Drain counter is loaded with the last index so it reaches zero on the final drain cycle
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector: ID-stage sources against the EX-stage load destination.
module hazard_unit #(
    parameter int unsigned RA_W = 4
) (
    input  logic            memread_ex,
    input  logic [RA_W-1:0] ra3_ex,
    input  logic [RA_W-1:0] ra1_id,
    input  logic [RA_W-1:0] ra2_id,
    input  logic            use_ra1_id,
    input  logic            use_ra2_id,
    output logic            load_use
);

    always_comb begin
        load_use = memread_ex &
                   ((use_ra1_id & (ra1_id == ra3_ex)) |
                    (use_ra2_id & (ra2_id == ra3_ex)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned RA_W  = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_id,
    input  logic             memread_ex,
    input  logic [RA_W-1:0]  ra3_ex,
    input  logic [RA_W-1:0]  ra1_id,
    input  logic [RA_W-1:0]  ra2_id,
    input  logic             use_ra1_id,
    input  logic             use_ra2_id,
    input  logic             pcsrc_ex,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    pctrl_state_t       state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               load_use;

    hazard_unit #(
        .RA_W (RA_W)
    ) u_hazard (
        .memread_ex (memread_ex),
        .ra3_ex     (ra3_ex),
        .ra1_id     (ra1_id),
        .ra2_id     (ra2_id),
        .use_ra1_id (use_ra1_id),
        .use_ra2_id (use_ra2_id),
        .load_use   (load_use)
    );

    // Controls act in the same cycle, so they decode state and inputs directly
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        case (state)
            RUN: begin
                if (pcsrc_ex) begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    id_ex_flush = 1'b1;
                end else if (halt_id) begin
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                end
            end
            DRAIN: begin
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        running = (state == RUN) || (state == DRAIN);
        done    = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (!pcsrc_ex && !load_use && halt_id) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] stall_q;
    logic             count_cycle;
    logic             count_stall;

    always_comb begin
        count_cycle = (state == RUN) || (state == DRAIN);
        count_stall = (state == RUN) && !pcsrc_ex && load_use;
    end

    // Saturating counters: hold at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            if (count_cycle && (cycle_q != '1)) cycle_q <= cycle_q + CNT_W'(1);
            if (count_stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        cycle_cnt = cycle_q;
        stall_cnt = stall_q;
    end
`else
    always_comb begin
        cycle_cnt = '0;
        stall_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (default and PIPELINE_CTRL_PERF_EN builds).
module tb_pipeline_ctrl;

    localparam int unsigned RA_W  = 4;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             halt_id;
    logic             memread_ex;
    logic [RA_W-1:0]  ra3_ex;
    logic [RA_W-1:0]  ra1_id;
    logic [RA_W-1:0]  ra2_id;
    logic             use_ra1_id;
    logic             use_ra2_id;
    logic             pcsrc_ex;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int unsigned passed = 0;
    int unsigned total  = 0;

    pipeline_ctrl #(
        .RA_W  (RA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt_id     (halt_id),
        .memread_ex  (memread_ex),
        .ra3_ex      (ra3_ex),
        .ra1_id      (ra1_id),
        .ra2_id      (ra2_id),
        .use_ra1_id  (use_ra1_id),
        .use_ra2_id  (use_ra2_id),
        .pcsrc_ex    (pcsrc_ex),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .running     (running),
        .done        (done),
        .cycle_cnt   (cycle_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed control vector {pc_en, if_id_en, if_id_flush, id_ex_flush, running, done}
    task automatic check_ctl(input string tag, input logic [5:0] exp);
        check(tag, {58'd0, pc_en, if_id_en, if_id_flush, id_ex_flush, running, done}, {58'd0, exp});
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] exp_cyc,
                             input logic [CNT_W-1:0] exp_stl);
`ifdef PIPELINE_CTRL_PERF_EN
        check({tag, "_cycle"}, 64'(cycle_cnt), 64'(exp_cyc));
        check({tag, "_stall"}, 64'(stall_cnt), 64'(exp_stl));
`else
        check({tag, "_cycle"}, 64'(cycle_cnt), 64'd0);
        check({tag, "_stall"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start      = 1'b0;
        halt_id    = 1'b0;
        memread_ex = 1'b0;
        ra3_ex     = '0;
        ra1_id     = '0;
        ra2_id     = '0;
        use_ra1_id = 1'b0;
        use_ra2_id = 1'b0;
        pcsrc_ex   = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        #1;
        check_ctl("reset_outputs", 6'b000000);
        check_cnt("reset", 0, 0);

        rst = 1'b1;
        tick();
        #1;
        check_ctl("idle_hold", 6'b000000);

        // Start pulse: IDLE outputs stay 0 in the start cycle, RUN the next
        start = 1'b1;
        #1;
        check_ctl("idle_with_start", 6'b000000);
        tick();
        start = 1'b0;
        #1;
        check_ctl("run_first", 6'b110010);
        check_cnt("run_first", 0, 0);
        tick();

        // RUN#2: load-use on ra1
        memread_ex = 1'b1; ra3_ex = 4'd5; ra1_id = 4'd5; use_ra1_id = 1'b1;
        #1;
        check_ctl("hazard_ra1", 6'b000110);
        tick();

        // RUN#3: matching ra1 unused, ra2 differs -> no stall
        use_ra1_id = 1'b0; ra2_id = 4'd3; use_ra2_id = 1'b1;
        #1;
        check_ctl("no_hazard_unused", 6'b110010);
        check_cnt("after_stall1", 2, 1);
        tick();

        // RUN#4: load-use on ra2
        ra2_id = 4'd5;
        #1;
        check_ctl("hazard_ra2", 6'b000110);
        tick();

        // RUN#5: branch wins over hazard and halt
        pcsrc_ex = 1'b1; halt_id = 1'b1;
        #1;
        check_ctl("branch_priority", 6'b111110);
        tick();
        clear_inputs();
        #1;
        check_ctl("stay_run_after_branch", 6'b110010);
        check_cnt("after_branch", 5, 2);

        // RUN#6: halt
        halt_id = 1'b1;
        #1;
        check_ctl("halt_run", 6'b011010);
        tick();

        // Three DRAIN cycles ignore branch/hazard/halt
        pcsrc_ex = 1'b1; memread_ex = 1'b1; ra3_ex = 4'd7; ra1_id = 4'd7; use_ra1_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ctl($sformatf("drain_%0d", i), 6'b011110);
            tick();
        end
        clear_inputs();
        #1;
        check_ctl("done", 6'b000001);
        check_cnt("done", 9, 2);

        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        #1;
        check_ctl("done_ignores_start", 6'b000001);
        check_cnt("done_hold", 9, 2);

        // Async reset mid-RUN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #1;
        check_ctl("run_before_async", 6'b110010);
        #2;
        rst = 1'b0;
        #1;
        check_ctl("async_reset", 6'b000000);
        check_cnt("async_reset", 0, 0);
        tick();
        rst = 1'b1;
        tick();
        #1;
        check_ctl("idle_after_async", 6'b000000);

`ifdef PIPELINE_CTRL_PERF_EN
        // Saturation: preload cycle counter to all-ones
        start = 1'b1;
        tick();
        start = 1'b0;
        force dut.cycle_q = '1;
        #1;
        release dut.cycle_q;
        tick();
        tick();
        #1;
        check("cycle_saturate", 64'(cycle_cnt), 64'(32'hFFFF_FFFF));
`else
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #1;
        check_cnt("no_perf_run", 0, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finish");
        $fatal(1, "timeout");
    end

endmodule
